i2s_wfifo_arbiter: RTL and testbench

I2S_WFIFO_ARBITER -- requirements
Module: i2s_wfifo_arbiter

---
 rtl/i2s_wfifo_arbiter_pkg.sv | 27 ++
 rtl/i2s_wfifo_arbiter_rr_arbiter2.sv | 22 ++
 rtl/i2s_wfifo_arbiter.sv | 148 ++++++++++++++
 tb/tb_i2s_wfifo_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_wfifo_arbiter_pkg.sv
// Shared i2s definitions for the write-FIFO arbiter: source count, buffer
// counter width, arbiter state encoding and the ping-pong buffer picker.
package i2s_wfifo_arbiter_pkg;

    localparam int unsigned NUM_SRC       = 2;
    localparam int unsigned BUF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVATE = 2'd1,
        ST_STREAM   = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    // Buffer 0 is preferred whenever it is available; never selects a buffer that is not ready.
    function automatic logic [NUM_SRC-1:0] pick_buffer(input logic [NUM_SRC-1:0] ready);
        logic [NUM_SRC-1:0] sel;
        sel = '0;
        if (ready[0]) begin
            sel[0] = 1'b1;
        end else if (ready[1]) begin
            sel[1] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/i2s_wfifo_arbiter_rr_arbiter2.sv
// Two-way round-robin selector.
//   req  : per-source request
//   last : index of the source granted most recently
//   gnt  : one-hot winner, 0 when nothing is requested
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the source that did not win last time takes the grant.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/i2s_wfifo_arbiter.sv
// Arbitrates two i2s sample sources onto a ping-pong write FIFO. A granted
// source streams words into the activated buffer until the buffer is full,
// the source flags end-of-burst, or the arbiter is disabled.
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : arbiter enable
//   src_valid/data/last : per-source word stream (source n at bit/slice n)
//   src_ready           : per-source accept (combinational)
//   grant               : one-hot owner of the active buffer
//   wfifo_ready/size    : buffer availability and capacity
//   wfifo_activate      : one-hot buffer activate
//   wfifo_strobe/data   : FIFO write port (combinational, zero latency)
//   buffers_sent        : wrapping count of released buffers
module i2s_wfifo_arbiter
    import i2s_wfifo_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [NUM_SRC-1:0]            grant,
    input  logic [NUM_SRC-1:0]            wfifo_ready,
    output logic [NUM_SRC-1:0]            wfifo_activate,
    input  logic [SIZE_WIDTH-1:0]         wfifo_size,
    output logic                          wfifo_strobe,
    output logic [DATA_WIDTH-1:0]         wfifo_data,
    output logic [BUF_CNT_WIDTH-1:0]      buffers_sent
);

    arb_state_e               state_q, state_d;
    logic [NUM_SRC-1:0]       grant_d;
    logic [NUM_SRC-1:0]       activate_d;
    logic [SIZE_WIDTH-1:0]    size_q, size_d;
    logic [SIZE_WIDTH-1:0]    count_q, count_d;
    logic [BUF_CNT_WIDTH-1:0] bufs_d;
    logic                     last_q, last_d;
    logic [NUM_SRC-1:0]       rr_gnt;
    logic                     room;
    logic                     gnt_last;

    rr_arbiter2 u_rr (
        .req  (src_valid),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    assign room     = (count_q < size_q);
    assign gnt_last = |(src_last & grant);

    // Only the owner is accepted, and nothing is accepted once disabled so the partial buffer closes cleanly.
    always_comb begin
        src_ready = '0;
        if ((state_q == ST_STREAM) && enable && room) begin
            src_ready = grant;
        end
    end

    assign wfifo_strobe = |(src_valid & src_ready);

    // Write data follows the owner directly; zero when nothing is granted.
    always_comb begin
        wfifo_data = '0;
        if (grant[0]) begin
            wfifo_data = src_data[0 +: DATA_WIDTH];
        end else if (grant[1]) begin
            wfifo_data = src_data[DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant;
        activate_d = wfifo_activate;
        size_d     = size_q;
        count_d    = count_q;
        bufs_d     = buffers_sent;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (|wfifo_ready) && (|src_valid)) begin
                    state_d = ST_ACTIVATE;
                    grant_d = rr_gnt;
                    last_d  = rr_gnt[1];
                end
            end
            ST_ACTIVATE: begin
                size_d  = wfifo_size;
                count_d = '0;
                // A buffer that went unavailable after the grant is never activated.
                if (|wfifo_ready) begin
                    activate_d = pick_buffer(wfifo_ready);
                    state_d    = ST_STREAM;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (!enable) begin
                    state_d = ST_RELEASE;
                end else if (wfifo_strobe) begin
                    count_d = count_q + SIZE_WIDTH'(1);
                    if ((count_d == size_q) || gnt_last) begin
                        state_d = ST_RELEASE;
                    end
                end else if (!room) begin
                    // Only reachable with a zero-sized buffer.
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                activate_d = '0;
                grant_d    = '0;
                bufs_d     = buffers_sent + BUF_CNT_WIDTH'(1);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            grant          <= '0;
            wfifo_activate <= '0;
            size_q         <= '0;
            count_q        <= '0;
            buffers_sent   <= '0;
            last_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            grant          <= grant_d;
            wfifo_activate <= activate_d;
            size_q         <= size_d;
            count_q        <= count_d;
            buffers_sent   <= bufs_d;
            last_q         <= last_d;
        end
    end

endmodule

// File: tb/tb_i2s_wfifo_arbiter.sv
// Scoreboard bench for i2s_wfifo_arbiter: per-source drivers feed word queues,
// expected strobes and activations are queued up front and popped by a monitor.
module tb_i2s_wfifo_arbiter;

    localparam int DW = 32;
    localparam int SW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [1:0]      src_valid;
    logic [2*DW-1:0] src_data;
    logic [1:0]      src_last;
    logic [1:0]      src_ready;
    logic [1:0]      grant;
    logic [1:0]      wfifo_ready;
    logic [1:0]      wfifo_activate;
    logic [SW-1:0]   wfifo_size;
    logic            wfifo_strobe;
    logic [DW-1:0]   wfifo_data;
    logic [15:0]     buffers_sent;

    i2s_wfifo_arbiter #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_last       (src_last),
        .src_ready      (src_ready),
        .grant          (grant),
        .wfifo_ready    (wfifo_ready),
        .wfifo_activate (wfifo_activate),
        .wfifo_size     (wfifo_size),
        .wfifo_strobe   (wfifo_strobe),
        .wfifo_data     (wfifo_data),
        .buffers_sent   (buffers_sent)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic last; } word_t;
    typedef struct { logic [31:0] data; logic [1:0] gnt; } strobe_t;
    typedef struct { logic [1:0] act; logic [1:0] gnt; } act_t;

    word_t   q0[$];
    word_t   q1[$];
    strobe_t exp_w[$];
    act_t    exp_a[$];

    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    logic [15:0] exp_bufs;
    logic [1:0]  hs;

    // Source drivers: present queue fronts after negedge, note handshakes before posedge.
    initial begin
        hs = 2'b00; src_valid = 2'b00; src_data = '0; src_last = 2'b00;
        forever begin
            @(negedge clk);
            if (hs[0] && q0.size() > 0) q0.delete(0);
            if (hs[1] && q1.size() > 0) q1.delete(0);
            #1;
            if (q0.size() > 0) begin
                src_valid[0] = 1'b1; src_data[31:0] = q0[0].data; src_last[0] = q0[0].last;
            end else begin
                src_valid[0] = 1'b0; src_data[31:0] = '0; src_last[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                src_valid[1] = 1'b1; src_data[63:32] = q1[0].data; src_last[1] = q1[0].last;
            end else begin
                src_valid[1] = 1'b0; src_data[63:32] = '0; src_last[1] = 1'b0;
            end
            #2;
            hs = src_valid & src_ready;
        end
    end

    // Monitor: compares every strobe and every activation against the queued expectations.
    initial begin
        logic [1:0] act_prev;
        strobe_t    es;
        act_t       ea;
        act_prev = 2'b00;
        forever begin
            @(negedge clk);
            #4;
            if (wfifo_strobe) begin
                strobe_cnt++;
                checks++;
                if (exp_w.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: data=%h grant=%b, no strobe expected", wfifo_data, grant);
                end else begin
                    es = exp_w.pop_front();
                    if (wfifo_data !== es.data || grant !== es.gnt) begin
                        errors++;
                        $display("FAIL strobe_word: got data=%h grant=%b, expected data=%h grant=%b",
                                 wfifo_data, grant, es.data, es.gnt);
                    end
                end
            end
            if (wfifo_activate != 2'b00 && act_prev == 2'b00) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_activate: activate=%b grant=%b", wfifo_activate, grant);
                end else begin
                    ea = exp_a.pop_front();
                    if (wfifo_activate !== ea.act || grant !== ea.gnt) begin
                        errors++;
                        $display("FAIL activation: got activate=%b grant=%b, expected activate=%b grant=%b",
                                 wfifo_activate, grant, ea.act, ea.gnt);
                    end
                end
            end
            act_prev = wfifo_activate;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic src_push(input int s, input logic [31:0] d, input logic l);
        word_t w;
        w.data = d; w.last = l;
        if (s == 0) q0.push_back(w); else q1.push_back(w);
    endtask

    task automatic exp_push(input logic [31:0] d, input logic [1:0] g);
        strobe_t e;
        e.data = d; e.gnt = g;
        exp_w.push_back(e);
    endtask

    task automatic act_push(input logic [1:0] a, input logic [1:0] g);
        act_t e;
        e.act = a; e.gnt = g;
        exp_a.push_back(e);
    endtask

    // Wait until every queued word is consumed and the arbiter is back to idle, then check the buffer count.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && exp_w.size() == 0 && exp_a.size() == 0
                     && grant == 2'b00 && wfifo_activate == 2'b00) && n < 300);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: pending words=%0d strobes=%0d activations=%0d, expected all 0",
                     name, q0.size() + q1.size(), exp_w.size(), exp_a.size());
        end
        check({name, "_buffers_sent"}, 64'(buffers_sent), 64'(exp_bufs));
    endtask

    task automatic wait_strobes(input string name, input int target);
        int n;
        n = 0;
        while (strobe_cnt < target && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (strobe_cnt < target) begin
            errors++;
            $display("FAIL %s_strobe_wait: got %0d strobes expected %0d", name, strobe_cnt, target);
        end
    endtask

    initial begin
        int s0;
        int n;
        rst = 1'b0; enable = 1'b1; wfifo_ready = 2'b11; wfifo_size = SW'(4); exp_bufs = 16'd0;
        tick(); tick();

        // Reset state
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_activate", 64'(wfifo_activate), 64'd0);
        check("rst_strobe", 64'(wfifo_strobe), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_data", 64'(wfifo_data), 64'd0);
        check("rst_buffers_sent", 64'(buffers_sent), 64'd0);
        rst = 1'b1;
        tick();

        // Both sources valid, size 2: grants alternate 01,10,01,10
        wfifo_ready = 2'b01; wfifo_size = SW'(2);
        for (int i = 0; i < 4; i++) begin
            src_push(0, 32'hA000_0000 + 32'(i), 1'b0);
            src_push(1, 32'hB000_0000 + 32'(i), 1'b0);
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 2; k++) begin
                if (b % 2 == 0) exp_push(32'hA000_0000 + 32'((b / 2) * 2 + k), 2'b01);
                else            exp_push(32'hB000_0000 + 32'((b / 2) * 2 + k), 2'b10);
            end
            act_push(2'b01, (b % 2 == 0) ? 2'b01 : 2'b10);
        end
        exp_bufs = exp_bufs + 16'd4;
        wait_drain("tie_alternate");

        // Source 0 only, size 4, six words: full buffer of 4, then a second buffer closed by last
        wfifo_size = SW'(4);
        for (int i = 0; i < 6; i++) begin
            src_push(0, 32'hC000_0000 + 32'(i), i == 5);
            exp_push(32'hC000_0000 + 32'(i), 2'b01);
        end
        act_push(2'b01, 2'b01);
        act_push(2'b01, 2'b01);
        exp_bufs = exp_bufs + 16'd2;
        wait_drain("size4_src0");

        // Source 1, size 8, last on 3rd word; buffer 1 is the only ready one
        wfifo_ready = 2'b10; wfifo_size = SW'(8);
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            src_push(1, 32'hD000_0000 + 32'(i), i == 2);
            exp_push(32'hD000_0000 + 32'(i), 2'b10);
        end
        act_push(2'b10, 2'b10);
        exp_bufs = exp_bufs + 16'd1;
        wait_drain("last_src1");
        check("last_src1_strobes", 64'(strobe_cnt - s0), 64'd3);

        // Both buffers ready: buffer 0 is activated
        wfifo_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            src_push(0, 32'hE000_0000 + 32'(i), i == 1);
            exp_push(32'hE000_0000 + 32'(i), 2'b01);
        end
        act_push(2'b01, 2'b01);
        exp_bufs = exp_bufs + 16'd1;
        wait_drain("ready11");

        // Zero-sized buffer releases with no strobe; the word goes into the next buffer
        wfifo_ready = 2'b01; wfifo_size = SW'(0);
        src_push(0, 32'hF000_0000, 1'b1);
        exp_push(32'hF000_0000, 2'b01);
        act_push(2'b01, 2'b01);
        act_push(2'b01, 2'b01);
        n = 0;
        while (wfifo_activate == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        check("size0_activate_seen", 64'(wfifo_activate), 64'd1);
        wfifo_size = SW'(1);
        exp_bufs = exp_bufs + 16'd2;
        wait_drain("size0");

        // Enable dropped after 2 of 8 words
        wfifo_size = SW'(8);
        for (int i = 0; i < 8; i++) src_push(0, 32'h1000_0000 + 32'(i), 1'b0);
        exp_push(32'h1000_0000, 2'b01);
        exp_push(32'h1000_0001, 2'b01);
        act_push(2'b01, 2'b01);
        s0 = strobe_cnt;
        wait_strobes("enable_drop", s0 + 2);
        enable = 1'b0;
        tick();
        tick();
        exp_bufs = exp_bufs + 16'd1;
        check("enable_drop_activate", 64'(wfifo_activate), 64'd0);
        check("enable_drop_buffers_sent", 64'(buffers_sent), 64'(exp_bufs));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("enable_low_idle", 64'({grant, wfifo_activate, wfifo_strobe}), 64'd0);
        end
        check("enable_drop_strobes", 64'(strobe_cnt - s0), 64'd2);
        q0.delete();
        tick();
        enable = 1'b1;
        wait_drain("enable_drop");

        // Reset mid-stream, then the first tie goes to source 0
        for (int i = 0; i < 8; i++) src_push(0, 32'h2000_0000 + 32'(i), 1'b0);
        exp_push(32'h2000_0000, 2'b01);
        exp_push(32'h2000_0001, 2'b01);
        act_push(2'b01, 2'b01);
        s0 = strobe_cnt;
        wait_strobes("mid_reset", s0 + 2);
        rst = 1'b0;
        q0.delete();
        #1;
        check("mid_reset_grant", 64'(grant), 64'd0);
        check("mid_reset_activate", 64'(wfifo_activate), 64'd0);
        check("mid_reset_strobe", 64'(wfifo_strobe), 64'd0);
        check("mid_reset_src_ready", 64'(src_ready), 64'd0);
        check("mid_reset_data", 64'(wfifo_data), 64'd0);
        check("mid_reset_buffers_sent", 64'(buffers_sent), 64'd0);
        exp_bufs = 16'd0;
        tick(); tick();
        rst = 1'b1;
        tick();
        src_push(0, 32'h3000_0000, 1'b1);
        src_push(1, 32'h4000_0000, 1'b1);
        exp_push(32'h3000_0000, 2'b01);
        exp_push(32'h4000_0000, 2'b10);
        act_push(2'b01, 2'b01);
        act_push(2'b01, 2'b10);
        exp_bufs = exp_bufs + 16'd2;
        wait_drain("post_reset_tie");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
